// File: rtl/toggle_pulse_rx_if.sv
// toggle_pulse_rx_if: source toggle, overflow clear and event status bundle for toggle_pulse_rx
interface toggle_pulse_rx_if #(
  parameter int CNT_W = 2
);
  logic             toggle_in;
  logic             clr_ovf;
  logic             pulse;
  logic             ack_toggle;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  modport master (
    output toggle_in, clr_ovf,
    input  pulse, ack_toggle, busy, pending, overflow
  );
  modport slave (
    input  toggle_in, clr_ovf,
    output pulse, ack_toggle, busy, pending, overflow
  );
endinterface

// File: rtl/toggle_pulse_rx.sv
// toggle_pulse_rx: synchronizes a source toggle, queues its transitions and replays each as a fixed-width pulse
module toggle_pulse_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_WIDTH = 1,
  parameter int CNT_W       = 2,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  toggle_pulse_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [7:0]       WLOAD    = 8'(PULSE_WIDTH - 1);
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [7:0]             wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       pend_q, pend_d;
  logic                   pulse_q, pulse_d;
  logic                   ack_q, ack_d;
  logic                   ovf_q, ovf_d;
  logic                   evt, have_pend, start, enq, drop;
  // synchronizer shift, edge reference and transition detect
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.toggle_in};
    edge_d    = sync_q[SYNC_STAGES-1];
    evt       = sync_q[SYNC_STAGES-1] ^ edge_q;
    have_pend = |pend_q;
  end
  // pulse sequencer: a new pulse may start from IDLE or straight out of the one-cycle GAP
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    start   = 1'b0;
    case (state_q)
      IDLE:    start = evt | have_pend;
      PULSE:   if (wcnt_q == 8'd0) state_d = GAP;
               else wcnt_d = wcnt_q - 8'd1;
      GAP:     begin
                 state_d = IDLE;
                 start   = evt | have_pend;
               end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = PULSE;
      wcnt_d  = WLOAD;
    end
    pulse_d = state_d == PULSE;
    ack_d   = ack_q ^ start;
  end
  // pending queue: a starting pulse takes a fresh evt first, otherwise pops one queued entry
  always_comb begin
    enq    = evt & ~start;
    drop   = enq & (pend_q == PEND_MAX);
    pend_d = (enq && !drop) ? pend_q + CNT_W'(1) :
             (start && !evt) ? pend_q - CNT_W'(1) : pend_q;
    ovf_d  = drop | (ovf_q & ~bus.clr_ovf);
  end
  // state registers with asynchronous reset that discards any in-flight or queued events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      edge_q  <= INIT_LEVEL;
      state_q <= IDLE;
      wcnt_q  <= 8'd0;
      pend_q  <= '0;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.pulse      = pulse_q;
  assign bus.ack_toggle = ack_q;
  assign bus.busy       = (state_q != IDLE) | have_pend;
  assign bus.pending    = pend_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_toggle_pulse_rx.sv
// tb_toggle_pulse_rx: directed scenarios across several pulse widths with hand-derived cycle expectations
module tb_toggle_pulse_rx;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  toggle_pulse_rx_if #(.CNT_W(2)) if1 ();
  toggle_pulse_rx_if #(.CNT_W(2)) if3 ();
  toggle_pulse_rx_if #(.CNT_W(2)) if4 ();
  toggle_pulse_rx_if #(.CNT_W(2)) if5 ();
  toggle_pulse_rx_if #(.CNT_W(2)) if8 ();
  toggle_pulse_rx #(.PULSE_WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  toggle_pulse_rx #(.PULSE_WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  toggle_pulse_rx #(.PULSE_WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  toggle_pulse_rx #(.PULSE_WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  toggle_pulse_rx #(.PULSE_WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if1.pulse, if1.ack_toggle, if1.busy, if1.pending, if1.overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_values got %b exp 000000", {if1.pulse, if1.ack_toggle, if1.busy, if1.pending, if1.overflow});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({if4.pulse, if4.ack_toggle, if4.busy, if4.pending, if4.overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold got %b exp 000000", {if4.pulse, if4.ack_toggle, if4.busy, if4.pending, if4.overflow});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_event();
    do_reset();
    repeat (3) @(negedge clk);
    if1.toggle_in = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      checks++;
      if (if1.pulse !== 1'(j == 3)) begin
        errors++;
        $display("FAIL single_pulse j=%0d got %b exp %b", j, if1.pulse, j == 3);
      end
      checks++;
      if (if1.ack_toggle !== 1'(j >= 3)) begin
        errors++;
        $display("FAIL single_ack j=%0d got %b exp %b", j, if1.ack_toggle, j >= 3);
      end
      checks++;
      if (if1.busy !== 1'(j == 3 || j == 4)) begin
        errors++;
        $display("FAIL single_busy j=%0d got %b exp %b", j, if1.busy, j == 3 || j == 4);
      end
    end
  endtask

  task automatic test_pulse_width();
    do_reset();
    repeat (3) @(negedge clk);
    if3.toggle_in = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      checks++;
      if (if3.pulse !== 1'(j >= 3 && j <= 5)) begin
        errors++;
        $display("FAIL width_pulse j=%0d got %b exp %b", j, if3.pulse, j >= 3 && j <= 5);
      end
      checks++;
      if (if3.pending !== 2'd0) begin
        errors++;
        $display("FAIL width_pending j=%0d got %0d exp 0", j, if3.pending);
      end
      checks++;
      if (if3.busy !== 1'(j >= 3 && j <= 6)) begin
        errors++;
        $display("FAIL width_busy j=%0d got %b exp %b", j, if3.busy, j >= 3 && j <= 6);
      end
    end
  endtask

  task automatic test_queueing();
    int   peak = 0;
    int   flips = 0;
    int   rises = 0;
    logic prev_ack = 1'b0;
    logic prev_pulse = 1'b0;
    logic exp_p;
    do_reset();
    repeat (3) @(negedge clk);
    if4.toggle_in = ~if4.toggle_in;
    for (int j = 1; j <= 26; j++) begin
      @(negedge clk);
      exp_p = (j >= 3 && j <= 6) || (j >= 8 && j <= 11) || (j >= 13 && j <= 16) || (j >= 18 && j <= 21);
      checks++;
      if (if4.pulse !== exp_p) begin
        errors++;
        $display("FAIL queue_pulse j=%0d got %b exp %b", j, if4.pulse, exp_p);
      end
      checks++;
      if (if4.busy !== 1'(j >= 3 && j <= 22)) begin
        errors++;
        $display("FAIL queue_busy j=%0d got %b exp %b", j, if4.busy, j >= 3 && j <= 22);
      end
      if (j == 6) begin
        checks++;
        if (if4.pending !== 2'd3) begin
          errors++;
          $display("FAIL queue_pending_j6 got %0d exp 3", if4.pending);
        end
      end
      if (int'(if4.pending) > peak) peak = int'(if4.pending);
      if (if4.ack_toggle !== prev_ack) flips++;
      if (if4.pulse && !prev_pulse) rises++;
      prev_ack   = if4.ack_toggle;
      prev_pulse = if4.pulse;
      if (j <= 3) if4.toggle_in = ~if4.toggle_in;
    end
    checks++;
    if (peak != 3) begin
      errors++;
      $display("FAIL queue_peak got %0d exp 3", peak);
    end
    checks++;
    if (if4.pending !== 2'd0) begin
      errors++;
      $display("FAIL queue_final_pending got %0d exp 0", if4.pending);
    end
    checks++;
    if (flips != 4 || if4.ack_toggle !== 1'b0) begin
      errors++;
      $display("FAIL queue_ack flips=%0d ack=%b exp flips=4 ack=0", flips, if4.ack_toggle);
    end
    checks++;
    if (rises != 4) begin
      errors++;
      $display("FAIL queue_rises got %0d exp 4", rises);
    end
    checks++;
    if (if4.overflow !== 1'b0) begin
      errors++;
      $display("FAIL queue_overflow got %b exp 0", if4.overflow);
    end
  endtask

  task automatic test_overflow();
    int   peak = 0;
    int   rises = 0;
    logic prev_pulse = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    if8.toggle_in = ~if8.toggle_in;
    for (int j = 1; j <= 50; j++) begin
      @(negedge clk);
      if (j == 6 || j == 7) begin
        checks++;
        if (if8.overflow !== 1'(j == 7)) begin
          errors++;
          $display("FAIL ovf_set j=%0d got %b exp %b", j, if8.overflow, j == 7);
        end
      end
      if (int'(if8.pending) > peak) peak = int'(if8.pending);
      if (if8.pulse && !prev_pulse) rises++;
      prev_pulse = if8.pulse;
      if (j <= 5) if8.toggle_in = ~if8.toggle_in;
    end
    checks++;
    if (rises != 4) begin
      errors++;
      $display("FAIL ovf_rises got %0d exp 4", rises);
    end
    checks++;
    if (peak != 3) begin
      errors++;
      $display("FAIL ovf_peak got %0d exp 3", peak);
    end
    checks++;
    if ({if8.busy, if8.pending, if8.overflow} !== 4'b0001) begin
      errors++;
      $display("FAIL ovf_idle_sticky got %b exp 0001", {if8.busy, if8.pending, if8.overflow});
    end
    if8.clr_ovf = 1'b1;
    @(negedge clk);
    if8.clr_ovf = 1'b0;
    checks++;
    if (if8.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b exp 0", if8.overflow);
    end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    repeat (3) @(negedge clk);
    if5.toggle_in = ~if5.toggle_in;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j <= 3) if5.toggle_in = ~if5.toggle_in;
    end
    checks++;
    if ({if5.pulse, if5.pending} !== 3'b110) begin
      errors++;
      $display("FAIL midrst_pre pulse/pending got %b exp 110", {if5.pulse, if5.pending});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if5.pulse, if5.pending, if5.busy, if5.ack_toggle, if5.overflow} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_clear got %b exp 000000", {if5.pulse, if5.pending, if5.busy, if5.ack_toggle, if5.overflow});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      checks++;
      if (if5.pulse !== 1'b0 || if5.busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet j=%0d pulse=%b busy=%b exp 0 0", j, if5.pulse, if5.busy);
      end
    end
  endtask

  task automatic test_reset_release_mismatch();
    int   rises = 0;
    logic prev_pulse = 1'b0;
    if1.toggle_in = 1'b1;
    do_reset();
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      checks++;
      if (if1.pulse !== 1'(j == 3)) begin
        errors++;
        $display("FAIL mismatch_pulse j=%0d got %b exp %b", j, if1.pulse, j == 3);
      end
      if (if1.pulse && !prev_pulse) rises++;
      prev_pulse = if1.pulse;
    end
    checks++;
    if (rises != 1 || if1.ack_toggle !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_count rises=%0d ack=%b exp 1 1", rises, if1.ack_toggle);
    end
  endtask

  initial begin
    if1.toggle_in = 1'b0; if1.clr_ovf = 1'b0;
    if3.toggle_in = 1'b0; if3.clr_ovf = 1'b0;
    if4.toggle_in = 1'b0; if4.clr_ovf = 1'b0;
    if5.toggle_in = 1'b0; if5.clr_ovf = 1'b0;
    if8.toggle_in = 1'b0; if8.clr_ovf = 1'b0;
    test_reset();
    test_single_event();
    test_pulse_width();
    test_queueing();
    test_overflow();
    test_reset_mid_pulse();
    test_reset_release_mismatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
